encoder_8_to_3_rr: RTL and testbench

- Registered, round-robin 8-to-3 event encoder; inverse of the 2-to-4 / 3-to-8 decoders.
- Captures rising edges on 8 request lines into a pending set.
- Emits one 3-bit index per valid/ready handshake, fair across requesters.
- Output index can drive a 3-to-8 decoder select directly, with out_valid as its enable G.

---
 rtl/encoder_8_to_3_rr.sv | 78 +++++++
 tb/tb_encoder_8_to_3_rr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8_to_3_rr.sv
// Registered round-robin 8-to-3 event encoder: rising edges on req are queued in a
// pending set and handed out one index per valid/ready handshake.
module encoder_8_to_3_rr #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [3:0] pend_cnt,
    output logic       ovf
);

    logic [7:0] req_q;
    logic [7:0] pending;
    logic [7:0] rise;
    logic [7:0] clr;
    logic [2:0] ptr;
    logic [2:0] base;
    logic [2:0] sel;
    logic       found;
    logic       load;
    logic       take;

    assign rise = req & ~req_q;
    assign load = !out_valid || out_ready;
    assign base = RR_EN ? ptr : 3'd0;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && pending[base + 3'(i)]) begin
                sel   = base + 3'(i);
                found = 1'b1;
            end
        end
    end

    assign take = load && found;
    assign clr  = take ? (8'd1 << sel) : 8'd0;

    always_comb begin
        pend_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pend_cnt = pend_cnt + 4'(pending[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // Tracking req through reset keeps lines held high from producing an event.
        req_q <= req;
        if (!rst_n) begin
            pending   <= 8'd0;
            out_valid <= 1'b0;
            out_code  <= 3'd0;
            ptr       <= 3'd0;
            ovf       <= 1'b0;
        end else begin
            // A rise on the bit being handed out re-pends it: set wins over clear.
            pending <= (pending & ~clr) | rise;
            ovf     <= |(rise & pending & ~clr);
            if (load) begin
                out_valid <= found;
                if (found) begin
                    out_code <= sel;
                    ptr      <= sel + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_encoder_8_to_3_rr.sv
// Bench for encoder_8_to_3_rr: directed vector table, reset sequences and random
// traffic compared against a behavioural model, for both RR_EN settings.
module tb_encoder_8_to_3_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;

    logic       valid_rr, valid_fp;
    logic [2:0] code_rr, code_fp;
    logic [3:0] cnt_rr, cnt_fp;
    logic       ovf_rr, ovf_fp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    encoder_8_to_3_rr #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(valid_rr), .out_code(code_rr), .pend_cnt(cnt_rr), .ovf(ovf_rr)
    );

    encoder_8_to_3_rr #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(valid_fp), .out_code(code_fp), .pend_cnt(cnt_fp), .ovf(ovf_fp)
    );

    // Behavioural model: index 0 is round-robin, index 1 is fixed priority.
    logic [7:0] m_req_q;
    logic [7:0] m_pend  [2];
    int         m_ptr   [2];
    logic       m_valid [2];
    int         m_code  [2];
    logic       m_ovf   [2];

    always @(posedge clk) begin
        logic [7:0] rise;
        logic [7:0] kept;
        int         sel;
        int         j;
        rise = req & ~m_req_q;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pend[k]  = 8'd0;
                m_valid[k] = 1'b0;
                m_code[k]  = 0;
                m_ptr[k]   = 0;
                m_ovf[k]   = 1'b0;
            end else begin
                sel = -1;
                if (!m_valid[k] || out_ready) begin
                    for (int i = 0; i < 8; i++) begin
                        j = (k == 0) ? (m_ptr[k] + i) % 8 : i;
                        if (sel < 0 && m_pend[k][j]) sel = j;
                    end
                    if (sel >= 0) begin
                        m_valid[k] = 1'b1;
                        m_code[k]  = sel;
                        m_ptr[k]   = (sel + 1) % 8;
                    end else begin
                        m_valid[k] = 1'b0;
                    end
                end
                kept = m_pend[k];
                if (sel >= 0) kept[sel] = 1'b0;
                m_ovf[k]  = |(rise & kept);
                m_pend[k] = kept | rise;
            end
        end
        m_req_q = req;
    end

    function automatic int popc(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("rr.valid", 32'(valid_rr), 32'(m_valid[0]));
        check("rr.code",  32'(code_rr),  32'(m_code[0]));
        check("rr.cnt",   32'(cnt_rr),   32'(popc(m_pend[0])));
        check("rr.ovf",   32'(ovf_rr),   32'(m_ovf[0]));
        check("fp.valid", 32'(valid_fp), 32'(m_valid[1]));
        check("fp.code",  32'(code_fp),  32'(m_code[1]));
        check("fp.cnt",   32'(cnt_fp),   32'(popc(m_pend[1])));
        check("fp.ovf",   32'(ovf_fp),   32'(m_ovf[1]));
    endtask

    // Inputs change 1 ns after the edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic [3:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    vec_t tab [29];

    initial begin
        // Expected round-robin instance outputs after the edge on which each row is applied.
        tab[0]  = '{8'h00, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
        tab[1]  = '{8'h4A, 1'b1, 1'b0, 3'd0, 4'd3, 1'b0};
        tab[2]  = '{8'h00, 1'b1, 1'b1, 3'd1, 4'd2, 1'b0};
        tab[3]  = '{8'h00, 1'b1, 1'b1, 3'd3, 4'd1, 1'b0};
        tab[4]  = '{8'h00, 1'b1, 1'b1, 3'd6, 4'd0, 1'b0};
        tab[5]  = '{8'h41, 1'b1, 1'b0, 3'd6, 4'd2, 1'b0};
        tab[6]  = '{8'h00, 1'b1, 1'b1, 3'd0, 4'd1, 1'b0};
        tab[7]  = '{8'h00, 1'b1, 1'b1, 3'd6, 4'd0, 1'b0};
        tab[8]  = '{8'h00, 1'b1, 1'b0, 3'd6, 4'd0, 1'b0};
        tab[9]  = '{8'h20, 1'b1, 1'b0, 3'd6, 4'd1, 1'b0};
        tab[10] = '{8'h20, 1'b1, 1'b1, 3'd5, 4'd0, 1'b0};
        tab[11] = '{8'h00, 1'b1, 1'b0, 3'd5, 4'd0, 1'b0};
        tab[12] = '{8'h14, 1'b0, 1'b0, 3'd5, 4'd2, 1'b0};
        tab[13] = '{8'h00, 1'b0, 1'b1, 3'd2, 4'd1, 1'b0};
        tab[14] = '{8'h00, 1'b0, 1'b1, 3'd2, 4'd1, 1'b0};
        tab[15] = '{8'h04, 1'b0, 1'b1, 3'd2, 4'd2, 1'b0};
        tab[16] = '{8'h00, 1'b1, 1'b1, 3'd4, 4'd1, 1'b0};
        tab[17] = '{8'h00, 1'b1, 1'b1, 3'd2, 4'd0, 1'b0};
        tab[18] = '{8'h00, 1'b1, 1'b0, 3'd2, 4'd0, 1'b0};
        tab[19] = '{8'h88, 1'b0, 1'b0, 3'd2, 4'd2, 1'b0};
        tab[20] = '{8'h00, 1'b0, 1'b1, 3'd3, 4'd1, 1'b0};
        tab[21] = '{8'h80, 1'b0, 1'b1, 3'd3, 4'd1, 1'b1};
        tab[22] = '{8'h00, 1'b0, 1'b1, 3'd3, 4'd1, 1'b0};
        tab[23] = '{8'h00, 1'b1, 1'b1, 3'd7, 4'd0, 1'b0};
        tab[24] = '{8'h01, 1'b1, 1'b0, 3'd7, 4'd1, 1'b0};
        tab[25] = '{8'h00, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0};
        tab[26] = '{8'h00, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
        tab[27] = '{8'h0F, 1'b0, 1'b0, 3'd0, 4'd4, 1'b0};
        tab[28] = '{8'h00, 1'b0, 1'b1, 3'd1, 4'd3, 1'b0};

        // Reset with all request lines held high: nothing may be captured.
        rst_n     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("rst_hold.valid", 32'(valid_rr), 32'd0);
            check("rst_hold.cnt",   32'(cnt_rr),   32'd0);
            check("rst_hold.ovf",   32'(ovf_rr),   32'd0);
        end

        for (int i = 0; i < 29; i++) begin
            req       = tab[i].req;
            out_ready = tab[i].rdy;
            step();
            check($sformatf("vec%0d.valid", i), 32'(valid_rr), 32'(tab[i].exp_valid));
            check($sformatf("vec%0d.code", i),  32'(code_rr),  32'(tab[i].exp_code));
            check($sformatf("vec%0d.cnt", i),   32'(cnt_rr),   32'(tab[i].exp_cnt));
            check($sformatf("vec%0d.ovf", i),   32'(ovf_rr),   32'(tab[i].exp_ovf));
        end

        // Mid-stream reset with an undelivered code and three pending bits.
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        step();
        check("midrst.valid", 32'(valid_rr), 32'd0);
        check("midrst.cnt",   32'(cnt_rr),   32'd0);
        check("midrst.code",  32'(code_rr),  32'd0);
        rst_n     = 1'b1;
        req       = 8'h82;
        out_ready = 1'b1;
        step();
        check("postrst.valid", 32'(valid_rr), 32'd0);
        check("postrst.cnt",   32'(cnt_rr),   32'd2);
        step();
        check("postrst.ptr0.code", 32'(code_rr),  32'd1);
        check("postrst.ptr0.valid", 32'(valid_rr), 32'd1);
        step();
        check("postrst.wrap.code", 32'(code_rr), 32'd7);
        req = 8'h00;
        step();

        // Random traffic with sparse line toggles, backpressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 249) != 0);
            req       = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
